carry_resolve_seq: RTL

//  Sequential stage directly downstream of the N-bit half-adder vector stage.
//  - Consumes a redundant (sum, carry) vector pair and iterates S'=S^(C<<1), C'=S&(C<<1)

---
 rtl/crs_pkg.sv | 9 +
 rtl/carry_resolve_seq_half_adder.sv | 13 +
 rtl/carry_resolve_seq.sv | 83 ++++++++
 3 files changed

// File: rtl/crs_pkg.sv
// crs_pkg: shared FSM state encoding and width helper for carry_resolve_seq
package crs_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  function automatic int crs_iter_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/carry_resolve_seq_half_adder.sv
// half_adder_nbit: bitwise half adder, sum=a^b, carry=a&b
// Ports: a, b (N-bit operands); sum, carry (N-bit results)
module half_adder_nbit #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic [N-1:0] carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

// File: rtl/carry_resolve_seq.sv
// carry_resolve_seq: iteratively resolves a redundant (sum, carry) pair into in_sum + (in_carry<<1)
// Ports: clk, rst (async active-high); in_valid/in_ready/in_sum/in_carry input handshake;
//        out_valid/out_ready/out_result/out_hi/out_iters output handshake.
// Macro CRS_PIPE_ACCEPT_EN: when defined, DONE accepts new operands on the same edge as the output handshake.
module carry_resolve_seq
  import crs_pkg::*;
#(
  parameter int N = 8,
  localparam int ITER_W = crs_iter_w(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_sum,
  input  logic [N-1:0]      in_carry,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_result,
  output logic [1:0]        out_hi,
  output logic [ITER_W-1:0] out_iters
);
  logic [1:0]        state_q, state_d;
  logic [N-1:0]      s_q, s_d, c_q, c_d, sh, s_step, c_step;
  logic [1:0]        hi_q, hi_d;
  logic [ITER_W-1:0] iters_q, iters_d;
  logic              accept;
  assign sh = {c_q[N-2:0], 1'b0};
  half_adder_nbit #(.N(N)) u_ha (
    .a     (s_q),
    .b     (sh),
    .sum   (s_step),
    .carry (c_step)
  );
  // rst gates in_ready so nothing is advertised while reset is held
`ifdef CRS_PIPE_ACCEPT_EN
  assign in_ready = !rst && (state_q == IDLE || (state_q == DONE && out_ready));
`else
  assign in_ready = !rst && state_q == IDLE;
`endif
  assign accept     = in_valid && in_ready;
  assign out_valid  = state_q == DONE;
  assign out_result = s_q;
  assign out_hi     = hi_q;
  assign out_iters  = iters_q;
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    hi_d    = hi_q;
    iters_d = iters_q;
    if (accept) begin
      s_d     = in_sum;
      c_d     = in_carry;
      hi_d    = 2'd0;
      iters_d = '0;
      state_d = in_carry == '0 ? DONE : BUSY;
    end else if (state_q == BUSY) begin
      s_d     = s_step;
      c_d     = c_step;
      hi_d    = hi_q + {1'b0, c_q[N-1]};
      iters_d = iters_q + ITER_W'(1);
      state_d = c_step == '0 ? DONE : BUSY;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      hi_q    <= 2'd0;
      iters_q <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      hi_q    <= hi_d;
      iters_q <= iters_d;
    end
  end
endmodule
